// File: rtl/approx_mul_pipe_pkg.sv
// Shared definitions for the pipelined approximate multiplier.
package approx_mul_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Upper bounds of the legal operand and tag widths.
  localparam int unsigned PL_W_MAX     = 16;
  localparam int unsigned PL_TAG_W_MAX = 16;

  // One operand pair as it travels with its sideband; fields sized for the
  // widest legal configuration, narrower builds use the low bits.
  typedef struct packed {
    logic [PL_W_MAX-1:0]     a;
    logic [PL_W_MAX-1:0]     b;
    logic                    mode;
    logic [PL_TAG_W_MAX-1:0] tag;
  } stage_payload_t;

  // Rounding bias for truncated products: half the weight of the lowest kept column.
  function automatic int unsigned comp_const(input int unsigned trunc,
                                             input int unsigned comp_en);
    if (comp_en != 0 && trunc > 0) begin
      return 32'd1 << (trunc - 1);
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/approx_mul_pipe_if.sv
// Operand/result handshake bundle for approx_mul_pipe.
interface approx_mul_pipe_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;
  logic             out_mode;

  // Upstream/downstream side: offers operands, consumes results.
  modport master (
    output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, out_mode
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, out_mode
  );
endinterface

// File: rtl/approx_pp_reduce.sv
// Partial-product generation, column truncation and carry-save reduction
// of the product matrix down to two rows.
module approx_pp_reduce
  import approx_mul_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned TRUNC = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         mode_i,
  output logic [2*W:0] row0_o,
  output logic [2*W:0] row1_o
);

  localparam int unsigned RW = 2*W + 1;
  localparam logic [RW-1:0] ALL_ONES    = '1;
  // Columns i+j >= TRUNC survive in approximate mode.
  localparam logic [RW-1:0] APPROX_KEEP = ALL_ONES << TRUNC;

  logic [RW-1:0] keep;
  logic [RW-1:0] pp_row;
  logic [RW-1:0] sum_q;
  logic [RW-1:0] car_q;
  logic [RW-1:0] sum_n;

  // Accumulate each shifted partial-product row through a 3:2 compressor;
  // carries leaving the top column are dropped since the true total fits RW bits.
  always_comb begin
    keep   = (mode_i == MODE_APPROX) ? APPROX_KEEP : ALL_ONES;
    sum_q  = '0;
    car_q  = '0;
    pp_row = '0;
    sum_n  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pp_row = (RW'({W{a_i[i]}} & b_i) << i) & keep;
      sum_n  = sum_q ^ car_q ^ pp_row;
      car_q  = ((sum_q & car_q) | (sum_q & pp_row) | (car_q & pp_row)) << 1;
      sum_q  = sum_n;
    end
    row0_o = sum_q;
    row1_o = car_q;
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage valid/ready pipelined exact/approximate unsigned multiplier.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned TRUNC   = 8,
  parameter int unsigned COMP_EN = 1,
  parameter int unsigned TAG_W   = 4
) (
  input logic               clk,
  input logic               rst,
  approx_mul_pipe_if.slave  bus
);

  localparam int unsigned PW = 2*W;
  localparam int unsigned RW = 2*W + 1;
  localparam logic [RW:0] COMP  = (RW+1)'(comp_const(TRUNC, COMP_EN));
  localparam logic [RW:0] P_MAX = (RW+1)'({PW{1'b1}});

  // Stage 1: captured operands
  logic             v1_q, v1_d;
  logic [W-1:0]     a1_q, a1_d, b1_q, b1_d;
  logic             m1_q, m1_d;
  logic [TAG_W-1:0] t1_q, t1_d;
  // Stage 2: reduced carry-save rows
  logic             v2_q, v2_d;
  logic [RW-1:0]    r0_q, r0_d, r1_q, r1_d;
  logic             m2_q, m2_d;
  logic [TAG_W-1:0] t2_q, t2_d;
  // Stage 3: final product
  logic             v3_q, v3_d;
  logic [PW-1:0]    p3_q, p3_d;
  logic             m3_q, m3_d;
  logic [TAG_W-1:0] t3_q, t3_d;

  logic          en1, en2, en3;
  logic [RW-1:0] row0, row1;
  logic [RW-1:0] cs_sum;
  logic [RW:0]   biased;

  approx_pp_reduce #(
    .W     (W),
    .TRUNC (TRUNC)
  ) u_reduce (
    .a_i    (a1_q),
    .b_i    (b1_q),
    .mode_i (m1_q),
    .row0_o (row0),
    .row1_o (row1)
  );

  // Each stage loads when its successor is empty or draining this cycle.
  always_comb begin
    en3 = !v3_q || bus.out_ready;
    en2 = !v2_q || en3;
    en1 = !v1_q || en2;
  end

  // Carry-propagate add, compensation bias and saturation for stage 3.
  always_comb begin
    cs_sum = r0_q + r1_q;
    biased = {1'b0, cs_sum} + ((m2_q == MODE_APPROX) ? COMP : '0);
    p3_d   = (biased > P_MAX) ? '1 : biased[PW-1:0];
  end

  // Next-state for all stages; payloads only move with a valid token so the
  // outputs keep the last result while idle.
  always_comb begin
    v1_d = v1_q; a1_d = a1_q; b1_d = b1_q; m1_d = m1_q; t1_d = t1_q;
    v2_d = v2_q; r0_d = r0_q; r1_d = r1_q; m2_d = m2_q; t2_d = t2_q;
    v3_d = v3_q; m3_d = m3_q; t3_d = t3_q;
    if (en1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        a1_d = bus.in_a;
        b1_d = bus.in_b;
        m1_d = bus.in_mode;
        t1_d = bus.in_tag;
      end
    end
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        r0_d = row0;
        r1_d = row1;
        m2_d = m1_q;
        t2_d = t1_q;
      end
    end
    if (en3) begin
      v3_d = v2_q;
      if (v2_q) begin
        m3_d = m2_q;
        t3_d = t2_q;
      end
    end
  end

  // Pipeline registers with synchronous reset discarding all in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; a1_q <= '0; b1_q <= '0; m1_q <= 1'b0; t1_q <= '0;
      v2_q <= 1'b0; r0_q <= '0; r1_q <= '0; m2_q <= 1'b0; t2_q <= '0;
      v3_q <= 1'b0; p3_q <= '0; m3_q <= 1'b0; t3_q <= '0;
    end else begin
      v1_q <= v1_d; a1_q <= a1_d; b1_q <= b1_d; m1_q <= m1_d; t1_q <= t1_d;
      v2_q <= v2_d; r0_q <= r0_d; r1_q <= r1_d; m2_q <= m2_d; t2_q <= t2_d;
      v3_q <= v3_d; m3_q <= m3_d; t3_q <= t3_d;
      if (en3 && v2_q) begin
        p3_q <= p3_d;
      end
    end
  end

  assign bus.in_ready  = en1;
  assign bus.out_valid = v3_q;
  assign bus.out_p     = p3_q;
  assign bus.out_tag   = t3_q;
  assign bus.out_mode  = m3_q;

endmodule
